// File: rtl/resp_mem_slave_if.sv
// resp_mem_slave_if -- req/ack bus between an interconnect slave port and a
// memory-backed responder.
//   req    master -> slave  transfer request, held with addr/cmd/wdata until ack
//   addr   master -> slave  32-bit byte address (bit 31 is the slave select)
//   cmd    master -> slave  0 = read, 1 = write
//   wdata  master -> slave  32-bit write data
//   ack    slave -> master  single-cycle acknowledge
//   rdata  slave -> master  32-bit read data, valid the cycle after ack
interface resp_mem_slave_if;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, cmd, wdata, input ack, rdata);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata);
endinterface

// File: rtl/resp_mem_slave.sv
// resp_mem_slave -- memory-backed responder for the req/ack interconnect bus.
// Accepts single read/write transfers, stores DEPTH 32-bit words, inserts
// WAIT_CYCLES wait states before a one-cycle ack, and returns read data in
// the cycle after ack.
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   bus   resp_mem_slave_if.slave (req/addr/cmd/wdata in, ack/rdata out)
// Build option:
//   RESP_MEM_OOR_EN  when defined, addresses with nonzero addr[30:ADDR_LSB+AW]
//                    are out of range: writes are dropped, reads return
//                    32'hDEAD_BEEF. When undefined the index wraps modulo DEPTH.
module resp_mem_slave #(
  parameter int DEPTH       = 16,
  parameter int ADDR_LSB    = 2,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  resp_mem_slave_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [3:0]      cnt_r;
  logic [AW-1:0]   idx_r;
  logic            cmd_r;
  logic [31:0]     wdata_r;
  logic            oor_r;
  logic [31:0]     mem_r [DEPTH];

  logic            accept_s;
  logic [AW-1:0]   idx_s;
  logic            oor_s;
  logic            unused_addr_s;

  // Only a slice of the address forms the index; fold the rest into a sink.
  assign unused_addr_s = ^bus.addr;

  // A new transfer can start from IDLE and from RDATA (back-to-back reads).
  assign accept_s = ((state_r == ST_IDLE) || (state_r == ST_RDATA)) && bus.req;
  assign idx_s    = bus.addr[ADDR_LSB +: AW];

  // Out-of-range decode; addr[31] never takes part in it.
  always_comb begin
    oor_s = 1'b0;
`ifdef RESP_MEM_OOR_EN
    if (((bus.addr & 32'h7FFF_FFFF) >> (ADDR_LSB + AW)) != 32'h0) begin
      oor_s = 1'b1;
    end else begin
      oor_s = 1'b0;
    end
`else
    oor_s = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_RDATA: begin
        if (bus.req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt_s = ST_ACK;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A dropped req mid-wait aborts the transfer; abort wins over expiry.
        if (!bus.req) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        if (cmd_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RDATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Request capture, wait counter, registered ack, array and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 4'd0;
      idx_r     <= '0;
      cmd_r     <= 1'b0;
      wdata_r   <= 32'h0;
      oor_r     <= 1'b0;
      bus.ack   <= 1'b0;
      bus.rdata <= 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else begin
      // ack is high exactly while the FSM sits in ACK.
      bus.ack <= (state_nxt_s == ST_ACK);

      if (accept_s) begin
        idx_r   <= idx_s;
        cmd_r   <= bus.cmd;
        wdata_r <= bus.wdata;
        oor_r   <= oor_s;
        cnt_r   <= WAIT_LOAD;
      end else if (state_r == ST_WAIT) begin
        if (!bus.req) begin
          cnt_r <= 4'd0;
        end else if (cnt_r != 4'd0) begin
          cnt_r <= cnt_r - 4'd1;
        end else begin
          cnt_r <= 4'd0;
        end
      end else begin
        cnt_r <= cnt_r;
      end

      // Commit or capture at the edge that ends the ACK cycle.
      if (state_r == ST_ACK) begin
        if (cmd_r) begin
          if (!oor_r) begin
            mem_r[idx_r] <= wdata_r;
          end
        end else if (oor_r) begin
          bus.rdata <= OOR_RDATA;
        end else begin
          bus.rdata <= mem_r[idx_r];
        end
      end
    end
  end

endmodule
